controle_trigger_echo: RTL



---
 rtl/controle_trigger_echo.sv | 137 +++++++++++++
 1 files changed

// File: rtl/controle_trigger_echo.sv
// -----------------------------------------------------------------------------
// controle_trigger_echo
//   Front end for an HC-SR04 class ultrasonic sensor. On a measurement request
//   it emits a fixed-width trigger pulse, waits for the echo, and forwards the
//   synchronised echo as a clean pulse for the downstream cm counter. Watchdogs
//   on the echo wait and on the echo width raise a sticky timeout flag.
//
// Parameters
//   T_TRIG     trigger width in clocks
//   T_ESPERA   max clocks from trigger end to echo rise
//   T_ECHO_MAX max echo width in clocks
//   N          shared cycle counter width, 2^N > max(T_TRIG,T_ESPERA,T_ECHO_MAX)
//
// Ports
//   clock      system clock
//   reset      asynchronous, active-high reset
//   medir      measurement request, level-sampled in the idle state
//   echo       raw sensor echo, asynchronous to clock
//   trigger    sensor trigger pulse
//   pulso      synchronised echo, gated to the measurement window
//   pronto     one-cycle strobe after a valid echo has ended
//   timeout    sticky error flag, cleared when the next measurement starts
//   db_estado  current state code
// -----------------------------------------------------------------------------
module controle_trigger_echo #(
  parameter int unsigned T_TRIG     = 500,
  parameter int unsigned T_ESPERA   = 50000,
  parameter int unsigned T_ECHO_MAX = 1900000,
  parameter int unsigned N          = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic       echo,
  output logic       trigger,
  output logic       pulso,
  output logic       pronto,
  output logic       timeout,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    S_INICIAL       = 3'd0,
    S_PREPARACAO    = 3'd1,
    S_ENVIA_TRIGGER = 3'd2,
    S_ESPERA_ECHO   = 3'd3,
    S_MEDIDA        = 3'd4,
    S_FINAL         = 3'd5,
    S_ERRO          = 3'd6
  } estado_t;

  localparam logic [N-1:0] TRIG_LAST   = N'(T_TRIG - 1);
  localparam logic [N-1:0] ESPERA_LAST = N'(T_ESPERA - 1);
  localparam logic [N-1:0] ECHO_LAST   = N'(T_ECHO_MAX - 1);

  estado_t        state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic           echo_meta_q, echo_s_q, echo_d_q;
  logic           timeout_q, timeout_d;
  logic           subida;

  // Two-flop synchroniser plus one delay stage for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_d_q    <= 1'b0;
    end else begin
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
      echo_d_q    <= echo_s_q;
    end
  end

  assign subida = echo_s_q & ~echo_d_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_INICIAL;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state. In espera_echo an echo edge outranks the watchdog, and in
  // medida an echo end outranks the width limit, so a tie never errors.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INICIAL:       if (medir) state_d = S_PREPARACAO;
      S_PREPARACAO:    state_d = S_ENVIA_TRIGGER;
      S_ENVIA_TRIGGER: if (cnt_q == TRIG_LAST) state_d = S_ESPERA_ECHO;
      S_ESPERA_ECHO: begin
        if (subida)                    state_d = S_MEDIDA;
        else if (cnt_q == ESPERA_LAST) state_d = S_ERRO;
      end
      S_MEDIDA: begin
        if (!echo_s_q)               state_d = S_FINAL;
        else if (cnt_q == ECHO_LAST) state_d = S_ERRO;
      end
      S_FINAL:         state_d = S_INICIAL;
      S_ERRO:          state_d = S_INICIAL;
      default:         state_d = S_INICIAL;
    endcase
  end

  // Shared counter: zero on every state change, so each timed state starts
  // from 0 and the limits are compared against LIMIT-1.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_ENVIA_TRIGGER || state_q == S_ESPERA_ECHO ||
                 state_q == S_MEDIDA) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Sticky error: raised together with entry to erro, dropped on entry to
  // preparacao.
  always_comb begin
    timeout_d = timeout_q;
    if (state_d == S_ERRO)            timeout_d = 1'b1;
    else if (state_d == S_PREPARACAO) timeout_d = 1'b0;
  end

  assign trigger   = (state_q == S_ENVIA_TRIGGER);
  assign pulso     = (state_q == S_MEDIDA);
  assign pronto    = (state_q == S_FINAL);
  assign timeout   = timeout_q;
  assign db_estado = state_q;

endmodule
